// File: rtl/global_iteration_controller_pkg.sv
// Shared configuration and FSM encoding for the global iteration controller.
// Default core count, iteration id width and controller state encoding.
package global_iteration_controller_pkg;

  localparam int DEF_CORE_NUM        = 4;
  localparam int DEF_ITERATION_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } gic_state_e;

endpackage

// File: rtl/global_iteration_controller_iteration_end_collector.sv
// Sticky per-core iteration-end mask with a clear and an all-cores-ended detect.
// all_end includes this cycle's qualified ends, so simultaneous ends are seen at once.
module iteration_end_collector #(
  parameter int CORE_NUM = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                enable,
  input  logic [CORE_NUM-1:0] core_end,
  input  logic [CORE_NUM-1:0] core_end_valid,
  output logic [CORE_NUM-1:0] end_mask,
  output logic                all_end
);

  logic [CORE_NUM-1:0] mask_r;
  logic [CORE_NUM-1:0] new_end_s;

  assign new_end_s = enable ? (core_end & core_end_valid) : {CORE_NUM{1'b0}};
  assign all_end   = enable && (&(mask_r | new_end_s));
  assign end_mask  = mask_r;

  // Accumulate qualified ends; clear wins over new ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_r <= {CORE_NUM{1'b0}};
    end else if (clear) begin
      mask_r <= {CORE_NUM{1'b0}};
    end else begin
      mask_r <= mask_r | new_end_s;
    end
  end

endmodule

// File: rtl/global_iteration_controller.sv
// Global iteration controller: sequences iterations across cores, waits for every
// core to end, drains, and repeats while vertices remain active up to a hard limit.
module global_iteration_controller
  import global_iteration_controller_pkg::*;
#(
  parameter int CORE_NUM        = DEF_CORE_NUM,
  parameter int ITERATION_WIDTH = DEF_ITERATION_WIDTH,
  parameter int MAX_ITERATION   = 16,
  parameter int DRAIN_CYCLES    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CORE_NUM-1:0]        core_iteration_end,
  input  logic [CORE_NUM-1:0]        core_iteration_end_valid,
  input  logic [CORE_NUM-1:0]        core_active_v_valid,
  output logic [ITERATION_WIDTH-1:0] iteration_id,
  output logic                       iteration_start,
  output logic                       busy,
  output logic                       done,
  output logic [CORE_NUM-1:0]        end_mask
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [ITERATION_WIDTH-1:0] LAST_ITER = ITERATION_WIDTH'(MAX_ITERATION - 1);

  gic_state_e                 state_r, next_state_s;
  logic [ITERATION_WIDTH-1:0] iteration_id_r;
  logic [DCW-1:0]             drain_cnt_r;
  logic                       activity_r;
  logic                       any_active_s, all_end_s, collect_en_s, collect_clear_s;
  logic                       drain_expire_s, stop_s;
  logic                       iteration_start_s, busy_s, done_s;
  logic                       iteration_start_r, busy_r, done_r;

  assign any_active_s    = |core_active_v_valid;
  assign collect_en_s    = (state_r == ST_RUN);
  assign collect_clear_s = (next_state_s == ST_START);
  assign drain_expire_s  = (state_r == ST_DRAIN) && (drain_cnt_r == DCW'(1));
  // Limit check comes before any increment, so the id can never wrap.
  assign stop_s          = !(activity_r || any_active_s) || (iteration_id_r == LAST_ITER);

  iteration_end_collector #(.CORE_NUM(CORE_NUM)) u_collector (
    .clk           (clk),
    .rst           (rst),
    .clear         (collect_clear_s),
    .enable        (collect_en_s),
    .core_end      (core_iteration_end),
    .core_end_valid(core_iteration_end_valid),
    .end_mask      (end_mask),
    .all_end       (all_end_s)
  );

  // State register plus registered FSM outputs aligned with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= ST_IDLE;
      iteration_start_r <= 1'b0;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
    end else begin
      state_r           <= next_state_s;
      iteration_start_r <= iteration_start_s;
      busy_r            <= busy_s;
      done_r            <= done_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:  if (start) next_state_s = ST_START; else next_state_s = ST_IDLE;
      ST_START: next_state_s = ST_RUN;
      ST_RUN:   if (all_end_s) next_state_s = ST_DRAIN; else next_state_s = ST_RUN;
      ST_DRAIN: begin
        if (drain_expire_s) next_state_s = stop_s ? ST_DONE : ST_START;
        else                next_state_s = ST_DRAIN;
      end
      ST_DONE:  if (start) next_state_s = ST_START; else next_state_s = ST_DONE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered above.
  always_comb begin
    iteration_start_s = 1'b0;
    busy_s            = 1'b0;
    done_s            = 1'b0;
    case (next_state_s)
      ST_START: begin iteration_start_s = 1'b1; busy_s = 1'b1; end
      ST_RUN:   busy_s = 1'b1;
      ST_DRAIN: busy_s = 1'b1;
      ST_DONE:  done_s = 1'b1;
      default:  busy_s = 1'b0;
    endcase
  end

  // Iteration id, sticky activity flag and drain down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      iteration_id_r <= {ITERATION_WIDTH{1'b0}};
      activity_r     <= 1'b0;
      drain_cnt_r    <= {DCW{1'b0}};
    end else begin
      if (next_state_s == ST_START) begin
        iteration_id_r <= (state_r == ST_DRAIN) ? iteration_id_r + ITERATION_WIDTH'(1)
                                                : {ITERATION_WIDTH{1'b0}};
      end else begin
        iteration_id_r <= iteration_id_r;
      end
      if (next_state_s == ST_START) begin
        activity_r <= 1'b0;
      end else if ((state_r == ST_RUN || state_r == ST_DRAIN) && any_active_s) begin
        activity_r <= 1'b1;
      end else begin
        activity_r <= activity_r;
      end
      if (state_r == ST_RUN && next_state_s == ST_DRAIN) begin
        drain_cnt_r <= DCW'(DRAIN_CYCLES);
      end else if (state_r == ST_DRAIN && drain_cnt_r != {DCW{1'b0}}) begin
        drain_cnt_r <= drain_cnt_r - DCW'(1);
      end else begin
        drain_cnt_r <= drain_cnt_r;
      end
    end
  end

  assign iteration_id    = iteration_id_r;
  assign iteration_start = iteration_start_r;
  assign busy            = busy_r;
  assign done            = done_r;

endmodule

// File: tb/tb_global_iteration_controller.sv
// Directed self-checking bench for global_iteration_controller (4 cores, drain 3, limit 3).
module tb_global_iteration_controller;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] ce, cev, cav;
  logic [7:0] iteration_id;
  logic       iteration_start, busy, done;
  logic [3:0] end_mask;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  global_iteration_controller #(
    .CORE_NUM(4), .ITERATION_WIDTH(8), .MAX_ITERATION(3), .DRAIN_CYCLES(3)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .start                   (start),
    .core_iteration_end      (ce),
    .core_iteration_end_valid(cev),
    .core_active_v_valid     (cav),
    .iteration_id            (iteration_id),
    .iteration_start         (iteration_start),
    .busy                    (busy),
    .done                    (done),
    .end_mask                (end_mask)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ce = 4'h0; cev = 4'h0; cav = 4'h0;
    tick(); tick();
    chk("rst_id", 32'(iteration_id), 32'd0);
    chk("rst_pulse", 32'(iteration_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mask", 32'(end_mask), 32'd0);
    rst = 1'b0; tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Start -> START for one cycle, then RUN
    start = 1'b1; tick(); start = 1'b0;
    chk("start_pulse", 32'(iteration_start), 32'd1);
    chk("start_id", 32'(iteration_id), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_mask", 32'(end_mask), 32'd0);
    tick();
    chk("run_pulse_low", 32'(iteration_start), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);

    // Ends without valid are ignored
    ce = 4'hF; cev = 4'h0; tick(); ce = 4'h0;
    chk("novalid_mask", 32'(end_mask), 32'd0);
    repeat (4) tick();
    chk("novalid_not_done", 32'(done), 32'd0);
    chk("novalid_still_busy", 32'(busy), 32'd1);
    chk("novalid_no_pulse", 32'(iteration_start), 32'd0);

    // All four end together, no activity -> drain 3 then DONE at id 0
    ce = 4'hF; cev = 4'hF; tick(); ce = 4'h0; cev = 4'h0;
    chk("allend_mask", 32'(end_mask), 32'hF);
    chk("drain1_busy", 32'(busy), 32'd1);
    tick(); tick();
    chk("drain3_busy", 32'(busy), 32'd1);
    chk("drain3_not_done", 32'(done), 32'd0);
    tick();
    chk("done_flag", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_id", 32'(iteration_id), 32'd0);
    cav = 4'hF; ce = 4'hF; cev = 4'hF; tick(); tick();
    cav = 4'h0; ce = 4'h0; cev = 4'h0;
    chk("done_hold", 32'(done), 32'd1);
    chk("done_hold_id", 32'(iteration_id), 32'd0);

    // Restart from DONE, then staggered ends with activity -> iteration 1
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_pulse", 32'(iteration_start), 32'd1);
    chk("restart_id", 32'(iteration_id), 32'd0);
    chk("restart_mask", 32'(end_mask), 32'd0);
    tick();
    ce = 4'h1; cev = 4'h1; tick();
    chk("mask_c0", 32'(end_mask), 32'h1);
    ce = 4'h2; cev = 4'h2; cav = 4'h4; start = 1'b1; tick();
    chk("mask_c1", 32'(end_mask), 32'h3);
    chk("start_ignored_run", 32'(iteration_start), 32'd0);
    start = 1'b0; cav = 4'h0; ce = 4'h4; cev = 4'h4; tick();
    chk("mask_c2", 32'(end_mask), 32'h7);
    ce = 4'h8; cev = 4'h8; tick(); ce = 4'h0; cev = 4'h0;
    chk("mask_c3", 32'(end_mask), 32'hF);
    chk("stagger_drain_busy", 32'(busy), 32'd1);
    tick(); tick();
    chk("stagger_drain3_pulse", 32'(iteration_start), 32'd0);
    tick();
    chk("iter1_pulse", 32'(iteration_start), 32'd1);
    chk("iter1_id", 32'(iteration_id), 32'd1);
    chk("iter1_mask", 32'(end_mask), 32'd0);

    // Constant activity: iteration 2 is the last, never 3
    cav = 4'hF;
    tick();
    ce = 4'hF; cev = 4'hF; tick(); ce = 4'h0; cev = 4'h0;
    tick(); tick(); tick();
    chk("iter2_pulse", 32'(iteration_start), 32'd1);
    chk("iter2_id", 32'(iteration_id), 32'd2);
    tick();
    ce = 4'hF; cev = 4'hF; tick(); ce = 4'h0; cev = 4'h0;
    tick(); tick(); tick();
    chk("limit_done", 32'(done), 32'd1);
    chk("limit_id", 32'(iteration_id), 32'd2);
    chk("limit_no_pulse", 32'(iteration_start), 32'd0);
    tick();
    chk("limit_hold_id", 32'(iteration_id), 32'd2);
    cav = 4'h0;

    // Reset in DRAIN, then clean restart
    start = 1'b1; tick(); start = 1'b0;
    chk("run3_id", 32'(iteration_id), 32'd0);
    tick();
    ce = 4'hF; cev = 4'hF; tick(); ce = 4'h0; cev = 4'h0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_pulse", 32'(iteration_start), 32'd0);
    chk("midrst_id", 32'(iteration_id), 32'd0);
    chk("midrst_mask", 32'(end_mask), 32'd0);
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("post_rst_pulse", 32'(iteration_start), 32'd1);
    chk("post_rst_id", 32'(iteration_id), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
